// File: rtl/demux_1to4_24bit_pkg.sv
// -----------------------------------------------------------------------------
// demux_defs
//   Shared constants and helpers for the 1-to-4 registered demultiplexer.
//   Other files pull these in with `import demux_defs::*;`.
//
//   WIDTH_DEFAULT      default data width of the input and of each channel
//   NUM_CH             number of output channels
//   SEL_W              width of the channel select
//   RESET_DATA_DEFAULT default value loaded into every channel data register
//   sel_decode()       one-hot decode of a channel select; an unknown select
//                      decodes to all zeros so that nothing is addressed
// -----------------------------------------------------------------------------
package demux_defs;

  localparam int WIDTH_DEFAULT = 24;
  localparam int NUM_CH        = 4;
  localparam int SEL_W         = 2;

  localparam logic [WIDTH_DEFAULT-1:0] RESET_DATA_DEFAULT = 24'h000000;

  typedef logic [NUM_CH-1:0] ch_mask_t;

  // The equality test yields x for an x/z select, which the if treats as
  // false, so such a select addresses no channel at all.
  function automatic ch_mask_t sel_decode(input logic [SEL_W-1:0] sel);
    ch_mask_t mask;
    mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        mask[k] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage : demux_defs

// File: rtl/demux_1to4_24bit_out_slot.sv
// -----------------------------------------------------------------------------
// out_slot
//   One-entry output register with its valid flag, used once per channel of
//   the demultiplexer. The slot presents its word until the consumer takes
//   it; a load and a drain may coincide so the slot never has to bubble.
//
//   Clock    in   rising-edge clock
//   Reset_n  in   asynchronous, active-low reset
//   Load     in   write Din into the slot at the next edge (only when Free)
//   Din      in   word to store
//   Ready    in   consumer takes the held word this cycle
//   Dout     out  held word (don't-care while Valid is 0)
//   Valid    out  slot holds a word
//   Free     out  slot can accept a word this cycle (empty or draining)
// -----------------------------------------------------------------------------
module out_slot
  import demux_defs::*;
#(
  parameter int               WIDTH      = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(RESET_DATA_DEFAULT)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Ready,
  output logic [WIDTH-1:0] Dout,
  output logic             Valid,
  output logic             Free
);

  // Drain-and-refill in one cycle is allowed, hence Ready counts as free.
  assign Free = ~Valid | Ready;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs as they were before the edge.
  // NOTE: the data register is reset as well as the flag, so consumers see a
  // defined RESET_DATA the moment reset is asserted rather than stale data.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Dout  <= RESET_DATA;
      Valid <= 1'b0;
    end else if (Load) begin
      Dout  <= Din;
      Valid <= 1'b1;
    end else if (Ready) begin
      // Drain with no reload; Dout keeps its last value.
      Valid <= 1'b0;
    end
  end

endmodule : out_slot

// File: rtl/demux_1to4_24bit.sv
// -----------------------------------------------------------------------------
// demux_1to4_24bit
//   Registered 1-to-4 distributor. One word per cycle arrives over a single
//   valid/ready source and is written into the channel chosen by Select, or
//   into all four channels when Broadcast is high. Each channel has its own
//   one-entry register and handshake, so a stalled consumer only blocks the
//   words addressed to it.
//
//   Clock      in   rising-edge clock
//   Reset_n    in   asynchronous, active-low reset
//   In         in   input data word
//   Select     in   destination channel 0..3 (ignored when Broadcast=1)
//   Broadcast  in   write the word to all four channels
//   InValid    in   In/Select/Broadcast are valid this cycle
//   InReady    out  word is accepted this cycle (combinational, 0 in reset)
//   Out0..Out3 out  channel data registers
//   OutValid   out  bit k: channel k holds a word
//   OutReady   in   bit k: consumer k takes its word this cycle
// -----------------------------------------------------------------------------
module demux_1to4_24bit
  import demux_defs::*;
#(
  parameter int               WIDTH      = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(RESET_DATA_DEFAULT)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [WIDTH-1:0]  In,
  input  logic [SEL_W-1:0]  Select,
  input  logic              Broadcast,
  input  logic              InValid,
  output logic              InReady,
  output logic [WIDTH-1:0]  Out0,
  output logic [WIDTH-1:0]  Out1,
  output logic [WIDTH-1:0]  Out2,
  output logic [WIDTH-1:0]  Out3,
  output logic [NUM_CH-1:0] OutValid,
  input  logic [NUM_CH-1:0] OutReady
);

  ch_mask_t         slot_free;
  ch_mask_t         target_mask;
  ch_mask_t         slot_load;
  logic             target_free;
  logic             accept;
  logic [WIDTH-1:0] slot_dout [NUM_CH];

  // Work out which channels the current word targets and whether they can all
  // take it. Broadcast needs every channel free so the word lands everywhere
  // at once or nowhere; an unknown Broadcast or Select addresses nothing.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    target_mask = '0;
    target_free = 1'b0;
    unique0 case (Broadcast)
      1'b0: begin
        target_mask = sel_decode(Select);
        target_free = |(target_mask & slot_free);
      end
      1'b1: begin
        target_mask = '1;
        target_free = &slot_free;
      end
      default: ;
    endcase
  end

  // Held low throughout reset even though the empty slots report free.
  assign InReady   = Reset_n & target_free;
  assign accept    = InValid & InReady;
  assign slot_load = target_mask & {NUM_CH{accept}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    out_slot #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_slot (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Load    (slot_load[k]),
      .Din     (In),
      .Ready   (OutReady[k]),
      .Dout    (slot_dout[k]),
      .Valid   (OutValid[k]),
      .Free    (slot_free[k])
    );
  end

  assign Out0 = slot_dout[0];
  assign Out1 = slot_dout[1];
  assign Out2 = slot_dout[2];
  assign Out3 = slot_dout[3];

endmodule : demux_1to4_24bit

// File: tb/tb_demux_1to4_24bit.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_24bit
//   Directed scenarios followed by randomized traffic. The reference model is
//   one FIFO of expected words per channel: an accepted word is appended to
//   the queue(s) of the channel(s) it targets, and whenever a consumer takes a
//   word the head of that channel's queue must match. Channel occupancy and
//   the expected InReady are derived from the queue contents.
// -----------------------------------------------------------------------------
module tb_demux_1to4_24bit;

  localparam int W = 24;

  logic          Clock     = 1'b0;
  logic          Reset_n   = 1'b0;
  logic [W-1:0]  In        = '0;
  logic [1:0]    Select    = '0;
  logic          Broadcast = 1'b0;
  logic          InValid   = 1'b0;
  logic          InReady;
  logic [W-1:0]  Out0, Out1, Out2, Out3;
  logic [3:0]    OutValid;
  logic [3:0]    OutReady  = 4'b0000;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q [4][$];

  demux_1to4_24bit dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .In        (In),
    .Select    (Select),
    .Broadcast (Broadcast),
    .InValid   (InValid),
    .InReady   (InReady),
    .Out0      (Out0),
    .Out1      (Out1),
    .Out2      (Out2),
    .Out3      (Out3),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] out_word(input int k);
    case (k)
      0:       return Out0;
      1:       return Out1;
      2:       return Out2;
      default: return Out3;
    endcase
  endfunction

  // Scoreboard / monitor: runs on the falling edge, looking at the handshakes
  // that the next rising edge will complete.
  always @(negedge Clock) begin
    logic [3:0] exp_valid;
    logic [3:0] free;
    logic       exp_ready;
    if (!Reset_n) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_valid[k] = (exp_q[k].size() != 0);
        free[k]      = !exp_valid[k] || (OutReady[k] === 1'b1);
      end
      check("mon_outvalid", 64'(OutValid), 64'(exp_valid));

      if ($isunknown(Broadcast) || (Broadcast === 1'b0 && $isunknown(Select)))
        exp_ready = 1'b0;
      else if (Broadcast)
        exp_ready = (free == 4'b1111);
      else
        exp_ready = free[Select];
      check("mon_inready", 64'(InReady), 64'(exp_ready));

      for (int k = 0; k < 4; k++) begin
        if (exp_valid[k] && OutReady[k] === 1'b1) begin
          logic [W-1:0] want;
          want = exp_q[k].pop_front();
          check($sformatf("mon_out%0d_data", k), 64'(out_word(k)), 64'(want));
        end
      end

      if (InValid === 1'b1 && exp_ready) begin
        if (Broadcast) begin
          for (int k = 0; k < 4; k++) exp_q[k].push_back(In);
        end else begin
          exp_q[Select].push_back(In);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic bc, input logic [W-1:0] din);
    InValid   = 1'b1;
    Select    = sel;
    Broadcast = bc;
    In        = din;
  endtask

  task automatic idle(input int n);
    InValid   = 1'b0;
    Broadcast = 1'b0;
    OutReady  = 4'b1111;
    repeat (n) tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("rst_outvalid", 64'(OutValid), 64'h0);
    check("rst_out0", 64'(Out0), 64'h0);
    check("rst_inready", 64'(InReady), 64'h0);
    repeat (2) tick();
    #2 Reset_n = 1'b1;

    // ---------------- reset mid-stream ----------------
    tick();
    OutReady = 4'b0000;
    send(2'd0, 1'b0, 24'h111111);
    tick();
    send(2'd2, 1'b0, 24'h222222);
    tick();
    InValid = 1'b0;
    check("mid_outvalid_before", 64'(OutValid), 64'b0101);
    #2 Reset_n = 1'b0;
    send(2'd1, 1'b0, 24'h333333);
    OutReady = 4'b1111;
    #1;
    check("mid_outvalid_async", 64'(OutValid), 64'h0);
    check("mid_out0_async", 64'(Out0), 64'h0);
    check("mid_out1_async", 64'(Out1), 64'h0);
    check("mid_out2_async", 64'(Out2), 64'h0);
    check("mid_out3_async", 64'(Out3), 64'h0);
    check("mid_inready_rst", 64'(InReady), 64'h0);
    tick();
    check("mid_inready_rst_edge", 64'(InReady), 64'h0);
    check("mid_outvalid_rst_edge", 64'(OutValid), 64'h0);
    InValid = 1'b0;
    #2 Reset_n = 1'b1;
    idle(1);

    // ---------------- unicast routing ----------------
    OutReady = 4'b1111;
    send(2'd2, 1'b0, 24'hA5A5A5);
    tick();
    check("uni_out2", 64'(Out2), 64'hA5A5A5);
    check("uni_valid1", 64'(OutValid), 64'b0100);
    send(2'd0, 1'b0, 24'h123456);
    tick();
    check("uni_out0", 64'(Out0), 64'h123456);
    check("uni_valid2", 64'(OutValid), 64'b0001);
    idle(2);

    // ---------------- per-channel backpressure ----------------
    OutReady = 4'b1110;
    send(2'd0, 1'b0, 24'h000011);
    tick();
    check("bp_out0_first", 64'(Out0), 64'h000011);
    send(2'd0, 1'b0, 24'h000022);
    #1;
    check("bp_inready_stall", 64'(InReady), 64'h0);
    tick();
    tick();
    check("bp_out0_hold", 64'(Out0), 64'h000011);
    check("bp_valid_hold", 64'(OutValid), 64'b0001);
    OutReady = 4'b1111;
    #1;
    check("bp_inready_release", 64'(InReady), 64'h1);
    tick();
    check("bp_out0_second", 64'(Out0), 64'h000022);
    send(2'd1, 1'b0, 24'h000033);
    tick();
    check("bp_out1", 64'(Out1), 64'h000033);
    idle(2);

    // ---------------- broadcast ----------------
    send(2'd1, 1'b1, 24'hFFFF00);
    tick();
    check("bc_valid", 64'(OutValid), 64'b1111);
    check("bc_out0", 64'(Out0), 64'hFFFF00);
    check("bc_out1", 64'(Out1), 64'hFFFF00);
    check("bc_out2", 64'(Out2), 64'hFFFF00);
    check("bc_out3", 64'(Out3), 64'hFFFF00);
    InValid  = 1'b0;
    OutReady = 4'b0111;
    tick();
    check("bc_ch3_only", 64'(OutValid), 64'b1000);
    send(2'd0, 1'b1, 24'h00ABCD);
    #1;
    check("bc_stall_inready", 64'(InReady), 64'h0);
    tick();
    check("bc_stall_valid", 64'(OutValid), 64'b1000);
    check("bc_stall_out3", 64'(Out3), 64'hFFFF00);
    InValid = 1'b0;

    // ---------------- drain and refill (channel 3 stays stalled) ----------------
    OutReady = 4'b0000;
    send(2'd1, 1'b0, 24'hBEEF00);
    tick();
    OutReady = 4'b0010;
    send(2'd1, 1'b0, 24'hBEEF01);
    #1;
    check("dr_inready", 64'(InReady), 64'h1);
    tick();
    check("dr_valid1", 64'(OutValid[1]), 64'h1);
    check("dr_out1", 64'(Out1), 64'hBEEF01);

    // ---------------- unknown select / broadcast ----------------
    OutReady = 4'b0000;
    send(2'd0, 1'b0, 24'h0C0C0C);
    tick();
    send(2'd2, 1'b0, 24'h0D0D0D);
    tick();
    check("unk_all_full", 64'(OutValid), 64'b1111);
    send(2'bx1, 1'b0, 24'h0E0E0E);
    #1;
    check("unk_sel_inready", 64'(InReady), 64'h0);
    tick();
    check("unk_sel_valid", 64'(OutValid), 64'b1111);
    send(2'd0, 1'bx, 24'h0F0F0F);
    #1;
    check("unk_bc_inready", 64'(InReady), 64'h0);
    tick();
    check("unk_bc_valid", 64'(OutValid), 64'b1111);
    Select = 2'd0;
    idle(3);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 1500; i++) begin
      InValid   = ($urandom_range(0, 3) != 0);
      Select    = 2'($urandom);
      Broadcast = ($urandom_range(0, 7) == 0);
      In        = W'($urandom);
      OutReady  = 4'($urandom) | ((i % 64 < 32) ? 4'b0000 : 4'b1010);
      tick();
    end

    idle(4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("end_queue%0d_empty", k), 64'(exp_q[k].size()), 64'h0);
    end
    check("end_outvalid", 64'(OutValid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_demux_1to4_24bit

// File: doc/demux_1to4_24bit.md
Name: demux_1to4_24bit

Overview:
- Registered 24-bit, 1-to-4 demultiplexer/distributor; the steering counterpart of the 4-to-1 24-bit mux.
- Accepts one word per cycle from a single valid/ready source and routes it to one of four output channels by Select, or to all four when Broadcast is high.
- Each channel has its own one-entry output register and valid/ready handshake, so a stalled consumer blocks only words addressed to it.
- Sits between a shared datapath producer and up to four downstream units.

Parameters:
- WIDTH, 24, data width of the input and of each output channel.
- RESET_DATA, 24'h000000, value loaded into every output data register on reset.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- In  input  WIDTH  input data word.
- Select  input  2  destination channel, 0..3; ignored when Broadcast=1.
- Broadcast  input  1  1 = write the word to all four channels.
- InValid  input  1  In/Select/Broadcast are valid this cycle.
- InReady  output  1  block accepts the word this cycle.
- Out0, Out1, Out2, Out3  output  WIDTH  channel data registers.
- OutValid  output  4  bit k = channel k holds a word.
- OutReady  input  4  bit k = consumer k takes the word this cycle.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-low, Reset_n.
- Reset (Reset_n=0, any time, including mid-transfer): OutValid=4'b0000 and Out0..Out3=RESET_DATA immediately, without waiting for a clock edge. Any in-flight word is discarded. InReady is 0 while Reset_n=0.
- Channel k is free when OutValid[k]=0 or OutReady[k]=1 (drain and refill in the same cycle is allowed).
- InReady is combinational:
  - Broadcast=0: InReady = channel Select is free.
  - Broadcast=1: InReady = all four channels are free.
  - InReady does not depend on InValid.
- Accept means InValid & InReady at a rising edge:
  - Unicast: Out[Select] <= In, OutValid[Select] <= 1. Other channels are untouched except by their own drain.
  - Broadcast: every Outk <= In, OutValid <= 4'b1111.
- Drain: OutValid[k] & OutReady[k] with no reload into k clears OutValid[k]. Outk keeps its last value; its data is don't-care while invalid.
- Latency: word accepted at edge N is visible with OutValid set after edge N; one cycle.
- Throughput: one word per cycle per channel when its consumer holds OutReady=1.
- Stability: while OutValid[k]=1 and OutReady[k]=0, Outk and OutValid[k] hold steady. This is a protocol guarantee to consumers.
- Unknown handling: Select containing x/z with Broadcast=0 forces InReady=0, so no channel is written (matches the mux default-x intent). Broadcast=x is handled the same way.
- Simultaneous events:
  - Unicast to k with drains on other channels: all take effect in the same cycle.
  - Broadcast with some consumers stalled: InReady=0, nothing written, the source retries.
- OutReady[k] asserted while OutValid[k]=0: no effect.

Decomposition:
- Shared package, demux_defs:
  - WIDTH_DEFAULT=24
  - NUM_CH=4
  - SEL_W=2
  - RESET_DATA_DEFAULT
- Sub-module out_slot, instantiated 4 times. One holding register plus its valid flag.
  - Inputs: Clock, Reset_n, Load, Din, Ready.
  - Outputs: Dout, Valid, Free.
- Top level holds the Select decode, the Broadcast AND of the Free flags, and InReady.

Test Plan:
- Reset mid-stream: with OutValid=4'b0101, drop Reset_n=0 between clock edges -> OutValid=0 and Out0..3=24'h000000 immediately, before the next edge; InReady=0 until Reset_n returns to 1.
- Unicast routing: OutReady=4'b1111; send In=24'hA5A5A5 with Select=2, then 24'h123456 with Select=0, back-to-back -> Out2=A5A5A5 with OutValid=4'b0100 after edge 1; Out0=123456 with OutValid=4'b0001 after edge 2.
- Per-channel backpressure: OutReady=4'b1110; send 24'h000011 with Select=0, then 24'h000022 with Select=0, then 24'h000033 with Select=1 ->
  - First word lands; the second word sees InReady=0 and stalls while Out0 holds 000011.
  - Only after raising OutReady[0], the second word is taken.
  - Select=1 words are not blocked once at the head of the stream.
- Broadcast: OutReady=4'b1111; send In=24'hFFFF00 with Broadcast=1 -> all Outk=FFFF00 and OutValid=4'b1111 one cycle later. Repeat with OutReady[3]=0 and channel 3 full -> InReady=0, no channel changes.
- Drain and refill: channel 1 full with OutReady[1]=1 and a new Select=1 word (24'hBEEF01) in the same cycle -> OutValid[1] stays 1 and Out1=BEEF01 next cycle, with no bubble.
- Unknown Select: InValid=1, Select=2'bx1, Broadcast=0 -> InReady=0 and OutValid unchanged.
